fsk_frame_sched: RTL and testbench

Frame scheduler in front of the 2-FSK modulator. It round-robin arbitrates two requesters that each offer 16-bit frames over a valid/ready handshake, latches the winning frame, and holds it stable on the modulator data bus. It sequences the modulator's active-low reset so that each frame starts at bit 15 with the modulator's bit counter cleared. It also times the 16-bit frame and inserts an idle gap between frames.

---
 rtl/fsk_frame_sched.sv | 105 ++++++++++
 tb/tb_fsk_frame_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_frame_sched.sv
// Frame scheduler for the 2-FSK modulator: round-robin grant of two 16-bit
// requesters, modulator reset sequencing, per-bit timing and inter-frame gap.
module fsk_frame_sched #(
    parameter int BIT_CYCLES = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        mod_rst,
    output logic [15:0] mod_data,
    output logic        busy,
    output logic        grant_id,
    output logic [3:0]  bit_idx,
    output logic        frame_done
);
    localparam int BW = $clog2(BIT_CYCLES);
    localparam int CW = 4 + BW;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = '1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_nxt;
    logic [GW-1:0] gap_cnt;
    logic          rr;
    logic          mod_rst_q;
    logic          grant_any;
    logic          winner;

    always_comb begin
        grant_any = rst & en & (state == IDLE) & (req0_valid | req1_valid);
        winner    = (req0_valid & req1_valid) ? ~rr : req1_valid;
        cyc_nxt   = cyc + 1'b1;
    end

    assign req0_ready = grant_any & ~winner;
    assign req1_ready = grant_any & winner;
    // A reset mid-frame silences the modulator in the same cycle, not one later.
    assign mod_rst    = mod_rst_q & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cyc        <= '0;
            gap_cnt    <= '0;
            rr         <= 1'b1;
            mod_rst_q  <= 1'b0;
            mod_data   <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (grant_any) begin
                    mod_data <= winner ? req1_data : req0_data;
                    grant_id <= winner;
                    rr       <= winner;
                    busy     <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    cyc       <= '0;
                    bit_idx   <= 4'hF;
                    mod_rst_q <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (cyc == CYC_LAST) begin
                    mod_rst_q  <= 1'b0;
                    bit_idx    <= '0;
                    frame_done <= 1'b1;
                    gap_cnt    <= '0;
                    if (GAP_CYCLES > 0) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    cyc     <= cyc_nxt;
                    // 15 - cyc/BIT_CYCLES is the bitwise inverse of the top nibble.
                    bit_idx <= ~cyc_nxt[CW-1 -: 4];
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsk_frame_sched.sv
// Randomised bench for fsk_frame_sched: timeline model keyed on acceptance cycle,
// directed literal checks, and a GAP_CYCLES=0 instance.
module tb_fsk_frame_sched;
    localparam int BC    = 16;
    localparam int GAPC  = 4;
    localparam int FRAME = 16 * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, en = 1'b0, v0 = 1'b0, v1 = 1'b0;
    logic [15:0] d0 = '0, d1 = '0;
    logic        r0, r1, mrst, busy, gid, fd;
    logic [15:0] mdata;
    logic [3:0]  bidx;

    logic        rst_b = 1'b0, en_b = 1'b0, v0_b = 1'b0, v1_b = 1'b0;
    logic [15:0] d0_b = '0, d1_b = '0;
    logic        r0_b, r1_b, mrst_b, busy_b, gid_b, fd_b;
    logic [15:0] mdata_b;
    logic [3:0]  bidx_b;

    fsk_frame_sched #(.BIT_CYCLES(BC), .GAP_CYCLES(GAPC)) u0 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .mod_rst(mrst), .mod_data(mdata), .busy(busy), .grant_id(gid),
        .bit_idx(bidx), .frame_done(fd)
    );

    fsk_frame_sched #(.BIT_CYCLES(2), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst(rst_b), .en(en_b),
        .req0_valid(v0_b), .req0_data(d0_b), .req0_ready(r0_b),
        .req1_valid(v1_b), .req1_data(d1_b), .req1_ready(r1_b),
        .mod_rst(mrst_b), .mod_data(mdata_b), .busy(busy_b), .grant_id(gid_b),
        .bit_idx(bidx_b), .frame_done(fd_b)
    );

    int tests = 0, fails = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0, auto_drv = 1'b0;
    int pv0 = 0, pv1 = 0, pdrop = 0;

    // model state
    bit          hf = 1'b0, m_gid = 1'b0, m_rr = 1'b1;
    int          t_acc = 0;
    logic [15:0] m_data = '0;
    bit          hs0 = 1'b0, hs1 = 1'b0;
    int          nfd = 0;
    int          glog_c[$];
    bit          glog_id[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Expected outputs follow from how many cycles have passed since the last acceptance.
    always @(negedge clk) begin
        int d;
        bit idle, w, acc, snd;
        d    = cyc_n - t_acc;
        idle = !hf || d >= 2 + FRAME + GAPC;
        w    = (v0 && v1) ? !m_rr : v1;
        acc  = rst && en && idle && (v0 || v1);
        snd  = hf && d >= 2 && d <= 1 + FRAME;
        if (chk_en) begin
            check("req0_ready", 32'(r0), 32'(acc && !w));
            check("req1_ready", 32'(r1), 32'(acc && w));
            check("busy", 32'(busy), 32'(hf && d >= 1 && d <= 1 + FRAME + GAPC));
            check("mod_rst", 32'(mrst), 32'(rst && snd));
            check("bit_idx", 32'(bidx), snd ? 32'(15 - (d - 2) / BC) : 32'd0);
            check("frame_done", 32'(fd), 32'(hf && d == 2 + FRAME));
            check("mod_data", 32'(mdata), 32'(m_data));
            check("grant_id", 32'(gid), 32'(m_gid));
            if (fd === 1'b1) nfd++;
            hs0 = v0 && (r0 === 1'b1);
            hs1 = v1 && (r1 === 1'b1);
            if (hs0 || hs1) begin
                glog_c.push_back(cyc_n);
                glog_id.push_back(hs1);
            end
        end
        if (!rst) begin
            hf = 1'b0; m_data = '0; m_gid = 1'b0; m_rr = 1'b1;
        end else if (acc) begin
            hf = 1'b1; t_acc = cyc_n; m_data = w ? d1 : d0; m_gid = w; m_rr = w;
        end
    end

    task automatic rnd_req(inout logic v, inout logic [15:0] d, input bit hs, input int pv);
        if (pv == 0) v = 1'b0;
        else if (hs || !v) begin
            v = 1'b0;
            if (int'($urandom_range(99)) < pv) begin v = 1'b1; d = 16'($urandom); end
        end else if (int'($urandom_range(99)) < pdrop) v = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (auto_drv) begin
            rnd_req(v0, d0, hs0, pv0);
            rnd_req(v1, d1, hs1, pv1);
        end
    endtask

    task automatic mid();
        #2;
    endtask

    initial begin
        int t, k, n0;
        step(); step(); step();
        rst = 1'b1; chk_en = 1'b1; mid();
        check("rst_busy", 32'(busy), 0);
        check("rst_mod_rst", 32'(mrst), 0);
        check("rst_mod_data", 32'(mdata), 0);
        check("rst_bit_idx", 32'(bidx), 0);

        // single frame timeline
        step(); en = 1'b1; v0 = 1'b1; d0 = 16'hA5C3; mid();
        check("t1_ready0", 32'(r0), 1);
        check("t1_ready1", 32'(r1), 0);
        step(); v0 = 1'b0; mid();
        check("t1_mod_data", 32'(mdata), 32'hA5C3);
        check("t1_load_mod_rst", 32'(mrst), 0);
        step(); mid();
        check("t1_first_bit", 32'(bidx), 15);
        check("t1_send_mod_rst", 32'(mrst), 1);
        repeat (255) step();
        mid();
        check("t1_last_bit", 32'(bidx), 0);
        check("t1_last_mod_rst", 32'(mrst), 1);
        step(); mid();
        check("t1_frame_done", 32'(fd), 1);
        check("t1_gap_mod_rst", 32'(mrst), 0);
        step(); mid();
        check("t1_done_pulse", 32'(fd), 0);
        repeat (3) step();
        mid();
        check("t1_idle_again", 32'(busy), 0);

        // contention alternates starting with req0
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        glog_c.delete(); glog_id.delete();
        auto_drv = 1'b1; pv0 = 100; pv1 = 100; pdrop = 0;
        for (int i = 0; i < 1200 && glog_c.size() < 4; i++) step();
        check("t2_grants", 32'(glog_c.size()), 4);
        if (glog_c.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_order", 32'(glog_id[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("t2_spacing", 32'(glog_c[i] - glog_c[i-1]), 262);
        end

        // lone requester is granted back-to-back
        pv0 = 0;
        glog_c.delete(); glog_id.delete();
        for (int i = 0; i < 1000 && glog_c.size() < 3; i++) step();
        check("t3_grants", 32'(glog_c.size()), 3);
        if (glog_c.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t3_id", 32'(glog_id[i]), 1);
            for (int i = 1; i < 3; i++) check("t3_spacing", 32'(glog_c[i] - glog_c[i-1]), 262);
        end

        // enable gating
        en = 1'b0; pv0 = 100; pv1 = 0;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin step(); k++; end
        check("t4_drain_timeout", 32'(k < 400), 1);
        repeat (10) step();
        mid();
        check("t4_blocked_ready", 32'(r0), 0);
        check("t4_blocked_busy", 32'(busy), 0);
        step(); en = 1'b1; mid();
        check("t4_accept", 32'(r0), 1);
        repeat (102) step();
        en = 1'b0; n0 = nfd;
        glog_c.delete(); glog_id.delete();
        repeat (400) step();
        check("t4_frame_done_cnt", 32'(nfd - n0), 1);
        check("t4_no_grant", 32'(glog_c.size()), 0);

        // reset mid-SEND
        step(); en = 1'b1; mid();
        check("t5_accept", 32'(r0), 1);
        t = cyc_n;
        repeat (102) step();
        auto_drv = 1'b0; rst = 1'b0; mid();
        check("t5_mod_rst_now", 32'(mrst), 0);
        step(); rst = 1'b1; en = 1'b0; v0 = 1'b0; v1 = 1'b0; mid();
        check("t5_busy", 32'(busy), 0);
        check("t5_mod_rst", 32'(mrst), 0);
        check("t5_mod_data", 32'(mdata), 0);
        check("t5_frame_done", 32'(fd), 0);
        n0 = nfd;
        repeat (300) step();
        check("t5_no_done", 32'(nfd - n0), 0);
        step(); en = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 16'h0F0F; d1 = 16'hF0F0; mid();
        check("t5_rr_ready0", 32'(r0), 1);
        check("t5_rr_ready1", 32'(r1), 0);
        step(); v0 = 1'b0; hs0 = 1'b1;

        // random traffic, enable and reset disturbances
        glog_c.delete(); glog_id.delete();
        auto_drv = 1'b1; pv0 = 30; pv1 = 30; pdrop = 3;
        for (int i = 0; i < 20000; i++) begin
            step();
            rst = ($urandom_range(3999) != 0);
            if (!en && $urandom_range(49) == 0) en = 1'b1;
            else if (en && $urandom_range(999) == 0) en = 1'b0;
        end
        check("rnd_activity", 32'(glog_c.size() > 20), 1);
        auto_drv = 1'b0; v0 = 1'b0; v1 = 1'b0; rst = 1'b1;

        // zero-gap instance, 2 cycles per bit
        step(); rst_b = 1'b1; en_b = 1'b1; v0_b = 1'b1; d0_b = 16'h1234; mid();
        check("t6_accept", 32'(r0_b), 1);
        step(); mid();
        check("t6_mod_data", 32'(mdata_b), 32'h1234);
        check("t6_load_mod_rst", 32'(mrst_b), 0);
        step(); mid();
        check("t6_first_bit", 32'(bidx_b), 15);
        check("t6_send_mod_rst", 32'(mrst_b), 1);
        repeat (31) step();
        mid();
        check("t6_last_bit", 32'(bidx_b), 0);
        check("t6_last_mod_rst", 32'(mrst_b), 1);
        step(); mid();
        check("t6_frame_done", 32'(fd_b), 1);
        check("t6_idle_busy", 32'(busy_b), 0);
        check("t6_reaccept", 32'(r0_b), 1);
        step(); mid();
        check("t6_done_pulse", 32'(fd_b), 0);
        check("t6_busy_again", 32'(busy_b), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
